// File: rtl/cond_flag_unit_if.sv
// cond_flag_unit_if
//   Execute-stage control and flag bus between the pipeline control logic and the
//   condition unit.
//   master : drives ValidE/StallE/FlushE, CondE, FlagWE, ALUFlags and the
//            PCSrcE/RegWriteE/MemWriteE requests; receives the gated requests,
//            CarryIn, Flags and AnnulCount.
//   slave  : the condition unit side (mirror of master).
interface cond_flag_unit_if #(
    parameter int unsigned COUNT_W = 16
);
    logic               ValidE;
    logic               StallE;
    logic               FlushE;
    logic [3:0]         CondE;
    logic [1:0]         FlagWE;
    logic [3:0]         ALUFlags;
    logic               PCSrcE;
    logic               RegWriteE;
    logic               MemWriteE;
    logic               CondExE;
    logic               PCSrcOut;
    logic               RegWriteOut;
    logic               MemWriteOut;
    logic               CarryIn;
    logic [3:0]         Flags;
    logic [COUNT_W-1:0] AnnulCount;

    modport master (
        output ValidE, StallE, FlushE, CondE, FlagWE, ALUFlags,
               PCSrcE, RegWriteE, MemWriteE,
        input  CondExE, PCSrcOut, RegWriteOut, MemWriteOut, CarryIn, Flags, AnnulCount
    );

    modport slave (
        input  ValidE, StallE, FlushE, CondE, FlagWE, ALUFlags,
               PCSrcE, RegWriteE, MemWriteE,
        output CondExE, PCSrcOut, RegWriteOut, MemWriteOut, CarryIn, Flags, AnnulCount
    );
endinterface

// File: rtl/cond_flag_unit.sv
// cond_flag_unit
//   Execute-stage condition unit of the pipelined ARM core. Holds the NZCV flag
//   register, updates it from the ALU under FlagWE, evaluates the cond field against
//   the stored flags and gates PC/register/memory writes of failed instructions.
//   Also supplies CarryIn and a saturating count of annulled instructions.
// Ports
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    cond_flag_unit_if.slave: E-stage controls in, gated controls, CarryIn,
//          Flags {N,Z,C,V} and AnnulCount out
module cond_flag_unit #(
    parameter int unsigned COUNT_W     = 16,
    parameter logic [3:0]  FLAGS_RESET = 4'b0000
) (
    input  logic            CLK,
    input  logic            RST_N,
    cond_flag_unit_if.slave bus
);
    logic [3:0]         flags_q;
    logic [COUNT_W-1:0] annul_q;
    logic               live;
    logic               cond_pass;
    logic               cond_ex;
    logic               n_flag, z_flag, c_flag, v_flag;

    assign n_flag = flags_q[3];
    assign z_flag = flags_q[2];
    assign c_flag = flags_q[1];
    assign v_flag = flags_q[0];

    // A flushed slot is dead regardless of ValidE.
    assign live = bus.ValidE & ~bus.FlushE;

    // Condition test always reads the flags registered before this edge (no bypass).
    always_comb begin
        cond_pass = 1'b0;
        case (bus.CondE)
            4'b0000: cond_pass = z_flag;
            4'b0001: cond_pass = ~z_flag;
            4'b0010: cond_pass = c_flag;
            4'b0011: cond_pass = ~c_flag;
            4'b0100: cond_pass = n_flag;
            4'b0101: cond_pass = ~n_flag;
            4'b0110: cond_pass = v_flag;
            4'b0111: cond_pass = ~v_flag;
            4'b1000: cond_pass = c_flag & ~z_flag;
            4'b1001: cond_pass = ~c_flag | z_flag;
            4'b1010: cond_pass = (n_flag == v_flag);
            4'b1011: cond_pass = (n_flag != v_flag);
            4'b1100: cond_pass = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_pass = z_flag | (n_flag != v_flag);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign cond_ex = live & cond_pass;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags_q <= FLAGS_RESET;
        end else if (cond_ex && !bus.StallE) begin
            if (bus.FlagWE[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagWE[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
        end
    end

    // Counts live instructions whose condition failed; sticks at all-ones.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            annul_q <= '0;
        end else if (live && !cond_pass && !bus.StallE && (annul_q != '1)) begin
            annul_q <= annul_q + COUNT_W'(1);
        end
    end

    assign bus.CondExE     = cond_ex;
    assign bus.PCSrcOut    = bus.PCSrcE & cond_ex;
    assign bus.RegWriteOut = bus.RegWriteE & cond_ex;
    assign bus.MemWriteOut = bus.MemWriteE & cond_ex;
    assign bus.CarryIn     = flags_q[1];
    assign bus.Flags       = flags_q;
    assign bus.AnnulCount  = annul_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit
//   Scoreboard bench for cond_flag_unit. The driver applies one E-stage slot per
//   cycle shortly after the rising edge, asks a behavioural model for the outputs
//   the slot must show, and queues them; the monitor pops one entry at every
//   falling edge and compares it with the DUT. Directed cases come first, then
//   random traffic with occasional mid-cycle resets.
module tb_cond_flag_unit;
    localparam int unsigned CW = 2;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cond_flag_unit_if #(.COUNT_W(CW)) cfu ();

    cond_flag_unit #(
        .COUNT_W    (CW),
        .FLAGS_RESET(4'b0000)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (cfu)
    );

    typedef struct {
        logic          condex;
        logic          pcsrc;
        logic          regw;
        logic          memw;
        logic          carry;
        logic [3:0]    flags;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: plain bits and an integer counter.
    bit   m_n, m_z, m_c, m_v;
    int   m_cnt;

    function automatic bit cond_holds(input logic [3:0] cond);
        case (cond)
            4'd0:  return m_z;
            4'd1:  return !m_z;
            4'd2:  return m_c;
            4'd3:  return !m_c;
            4'd4:  return m_n;
            4'd5:  return !m_n;
            4'd6:  return m_v;
            4'd7:  return !m_v;
            4'd8:  return m_c && !m_z;
            4'd9:  return !m_c || m_z;
            4'd10: return m_n == m_v;
            4'd11: return m_n != m_v;
            4'd12: return !m_z && (m_n == m_v);
            4'd13: return m_z || (m_n != m_v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_n = 0; m_z = 0; m_c = 0; m_v = 0;
        m_cnt = 0;
    endtask

    task automatic push_expected(input bit ok);
        exp_t e;
        e.condex = ok;
        e.pcsrc  = ok & cfu.PCSrcE;
        e.regw   = ok & cfu.RegWriteE;
        e.memw   = ok & cfu.MemWriteE;
        e.carry  = m_c;
        e.flags  = {m_n, m_z, m_c, m_v};
        e.cnt    = CW'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit v, input bit s, input bit f, input logic [3:0] cond,
                         input logic [1:0] fw, input logic [3:0] alu,
                         input bit pc, input bit rw, input bit mw);
        cfu.ValidE    = v;
        cfu.StallE    = s;
        cfu.FlushE    = f;
        cfu.CondE     = cond;
        cfu.FlagWE    = fw;
        cfu.ALUFlags  = alu;
        cfu.PCSrcE    = pc;
        cfu.RegWriteE = rw;
        cfu.MemWriteE = mw;
    endtask

    // One pipeline slot: drive, queue expectation, then advance the model to the
    // state it must hold after the next rising edge.
    task automatic step(input bit v, input bit s, input bit f, input logic [3:0] cond,
                        input logic [1:0] fw, input logic [3:0] alu,
                        input bit pc, input bit rw, input bit mw);
        bit live, ok;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(v, s, f, cond, fw, alu, pc, rw, mw);
        live = v && !f;
        ok   = live && cond_holds(cond);
        push_expected(ok);
        if (!s) begin
            if (ok) begin
                if (fw[1]) begin m_n = alu[3]; m_z = alu[2]; end
                if (fw[0]) begin m_c = alu[1]; m_v = alu[0]; end
            end else if (live && m_cnt < CMAX) begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 4'he, 2'b00, 4'h0, 0, 0, 0);
    endtask

    // Reset asserted between edges; the slot in flight is dropped.
    task automatic reset_mid();
        @(posedge clk);
        #2;
        drive(1, 0, 0, 4'he, 2'b11, 4'hf, 1, 1, 1);
        #1;
        rst_n = 1'b0;
        model_reset();
        push_expected(1'b1);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("CondExE",     32'(cfu.CondExE),     32'(e.condex));
                cmp("PCSrcOut",    32'(cfu.PCSrcOut),    32'(e.pcsrc));
                cmp("RegWriteOut", 32'(cfu.RegWriteOut), 32'(e.regw));
                cmp("MemWriteOut", 32'(cfu.MemWriteOut), 32'(e.memw));
                cmp("CarryIn",     32'(cfu.CarryIn),     32'(e.carry));
                cmp("Flags",       32'(cfu.Flags),       32'(e.flags));
                cmp("AnnulCount",  32'(cfu.AnnulCount),  32'(e.cnt));
            end
        end
    end

    initial begin : driver
        int waited;
        drive(0, 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0);
        model_reset();
        #12;

        // Reset values; EQ fails on Z=0, AL passes.
        step(1, 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0);
        step(1, 0, 0, 4'he, 2'b00, 4'h0, 0, 0, 0);
        reset_mid();

        // SUBS-style setter, then EQ sees Z=1 one slot later.
        step(1, 0, 0, 4'he, 2'b11, 4'b0100, 0, 1, 0);
        step(1, 0, 0, 4'h0, 2'b00, 4'h0, 0, 1, 0);

        // ANDS-style partial update keeps C,V.
        step(1, 0, 0, 4'he, 2'b11, 4'b0011, 0, 0, 0);
        step(1, 0, 0, 4'he, 2'b10, 4'b1000, 0, 0, 0);
        idle();

        // Failed condition: no writes, no flag change, one annul.
        reset_mid();
        step(1, 0, 0, 4'h0, 2'b11, 4'hf, 1, 0, 1);
        idle();

        // Stall holds a passing setter; flush kills a live slot.
        step(1, 1, 0, 4'he, 2'b11, 4'hf, 1, 1, 1);
        step(1, 1, 0, 4'he, 2'b11, 4'hf, 1, 1, 1);
        step(1, 0, 0, 4'he, 2'b11, 4'hf, 1, 1, 1);
        step(1, 0, 1, 4'he, 2'b11, 4'h0, 1, 1, 1);
        step(1, 0, 1, 4'h0, 2'b11, 4'h0, 1, 1, 1);
        idle();

        // Saturation: five reserved-cond slots with a 2-bit counter.
        reset_mid();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 4'hf, 2'b11, 4'hf, 1, 1, 1);
        idle();
        reset_mid();
        idle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_mid();
            end else begin
                step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20,
                     $urandom_range(0, 99) < 10, 4'($urandom), 2'($urandom),
                     4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end
        end
        idle();

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
